// File: rtl/fanout_mcast_fifo_pkg.sv
// Shared link package for the multicast fan-out FIFO.
// Holds the forward/back-prop token types, the destination mask type,
// the ingress FSM state enum and a small header-mask helper.
// Link widths are fixed here; the top's WIDTH_DATA / NUM_OUT parameters
// must match these values.
package fanout_mcast_fifo_pkg;

    localparam int unsigned LINK_WIDTH_DATA = 32;
    localparam int unsigned LINK_NUM_OUT    = 4;

    // Forward token: v valid, a header, r last, d data.
    typedef struct packed {
        logic                       v;
        logic                       a;
        logic                       r;
        logic [LINK_WIDTH_DATA-1:0] d;
    } FTk_t;

    // Back-prop token: n stall.
    typedef struct packed {
        logic n;
    } BTk_t;

    typedef logic [LINK_NUM_OUT-1:0] mask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } ing_state_e;

    // The header carries its destination mask in the low data bits.
    function automatic mask_t header_mask(input FTk_t tok);
        return tok.d[LINK_NUM_OUT-1:0];
    endfunction

endpackage

// File: rtl/fanout_mcast_fifo_mcast_buff.sv
// mcast_buff: shared circular storage with read/write pointers and an
// occupancy counter. Each entry is written once; the head entry is read
// combinationally so a token written at one edge is visible the next cycle.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   push_i    in   write request (honoured when not full, or when popping)
//   wdata_i   in   entry to write
//   pop_i     in   remove head entry (ignored when empty)
//   rdata_o   out  head entry
//   count_o   out  current occupancy
//   empty_o   out  occupancy == 0
//   full_o    out  occupancy == DEPTH
module mcast_buff #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A simultaneous pop frees the slot, so a push at full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: empty gates everything read from it.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fanout_mcast_fifo.sv
// fanout_mcast_fifo: single-input multicast FIFO. Messages (header + body)
// are stored once per token with the header's destination mask and handed
// out to every masked output channel; the entry leaves when the last
// masked channel has taken it.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   I_FTk   in   upstream forward token
//   O_BTk   out  upstream stall (registered occupancy >= THRESHOLD)
//   O_FTk   out  per-channel forward tokens
//   I_BTk   in   per-channel stalls
//   O_Grt   out  destination mask of head entry (0 when empty)
//   O_Err   out  sticky protocol / overflow error
//
// Ingress FSM:
//   state | meaning
//   IDLE  | waiting for a header
//   BODY  | storing body tokens under the latched mask
//   DROP  | discarding a zero-mask message until its last token
module fanout_mcast_fifo
    import fanout_mcast_fifo_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = LINK_WIDTH_DATA,
    parameter int unsigned DEPTH_FIFO = 16,
    parameter int unsigned THRESHOLD  = DEPTH_FIFO - 4,
    parameter int unsigned NUM_OUT    = LINK_NUM_OUT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  FTk_t                    I_FTk,
    output BTk_t                    O_BTk,
    output FTk_t [NUM_OUT-1:0]      O_FTk,
    input  BTk_t [NUM_OUT-1:0]      I_BTk,
    output logic [NUM_OUT-1:0]      O_Grt,
    output logic                    O_Err
);

    localparam int unsigned CW      = $clog2(DEPTH_FIFO) + 1;
    localparam int unsigned ENTRY_W = NUM_OUT + 3 + WIDTH_DATA;

    ing_state_e state_q, state_d;
    mask_t      mask_q, mask_d;
    mask_t      hdr_mask;
    mask_t      store_mask;
    logic       store;
    logic       mask_ld;
    logic       proto_err;

    logic                err_q, err_d;
    logic                btk_q, btk_d;
    mask_t               sent_q, sent_d;
    mask_t               out_v;
    mask_t               acc;
    logic                pop;
    logic                overflow;

    logic [ENTRY_W-1:0]  wdata;
    logic [ENTRY_W-1:0]  rdata;
    logic [CW-1:0]       count;
    logic                empty;
    logic                full;
    mask_t               head_mask;
    FTk_t                head_tok;

    assign hdr_mask = header_mask(I_FTk);

    // ---------------- ingress FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- ingress FSM: next state ----------------
    // A header seen in BODY restarts the message exactly as from IDLE.
    always_comb begin
        state_d = state_q;
        if (I_FTk.v) begin
            unique case (state_q)
                IDLE, BODY: begin
                    if (I_FTk.a) begin
                        if (hdr_mask != '0) state_d = I_FTk.r ? IDLE : BODY;
                        else                state_d = I_FTk.r ? IDLE : DROP;
                    end else if (state_q == BODY && I_FTk.r) begin
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (I_FTk.r) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- ingress FSM: outputs ----------------
    always_comb begin
        store      = 1'b0;
        store_mask = mask_q;
        mask_ld    = 1'b0;
        proto_err  = 1'b0;
        if (I_FTk.v) begin
            unique case (state_q)
                IDLE, BODY: begin
                    if (I_FTk.a) begin
                        proto_err = (state_q == BODY);
                        if (hdr_mask != '0) begin
                            store      = 1'b1;
                            store_mask = hdr_mask;
                            mask_ld    = 1'b1;
                        end
                    end else if (state_q == BODY) begin
                        store = 1'b1;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mask_d = mask_ld ? hdr_mask : mask_q;

    // ---------------- shared storage ----------------
    assign wdata = {store_mask, I_FTk};

    mcast_buff #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH_FIFO)
    ) u_buff (
        .clock   (clock),
        .reset   (reset),
        .push_i  (store),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    assign head_mask = rdata[ENTRY_W-1 -: NUM_OUT];
    assign head_tok  = rdata[ENTRY_W-NUM_OUT-1:0];

    // ---------------- egress ----------------
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            out_v[i] = !empty && head_mask[i] && !sent_q[i];
            acc[i]   = out_v[i] && !I_BTk[i].n;
            O_FTk[i] = out_v[i] ? head_tok : '0;
        end
    end

    // Pop once every masked channel has taken the head, whether in this
    // cycle or an earlier one.
    assign pop    = !empty && (((sent_q | acc) & head_mask) == head_mask);
    assign sent_d = pop ? '0 : (sent_q | acc);

    assign overflow = store && full && !pop;
    assign err_d    = err_q | proto_err | overflow;
    assign btk_d    = (count >= CW'(THRESHOLD));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            sent_q <= '0;
            err_q  <= 1'b0;
            btk_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            sent_q <= sent_d;
            err_q  <= err_d;
            btk_q  <= btk_d;
        end
    end

    assign O_BTk.n = btk_q;
    assign O_Grt   = empty ? '0 : head_mask;
    assign O_Err   = err_q;

endmodule

// File: tb/tb_fanout_mcast_fifo.sv
module tb_fanout_mcast_fifo;
    import fanout_mcast_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int THR   = 12;
    localparam int NO    = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    FTk_t                 I_FTk;
    BTk_t                 O_BTk;
    FTk_t [NO-1:0]        O_FTk;
    BTk_t [NO-1:0]        I_BTk;
    logic [NO-1:0]        O_Grt;
    logic                 O_Err;

    fanout_mcast_fifo #(
        .WIDTH_DATA (32),
        .DEPTH_FIFO (DEPTH),
        .THRESHOLD  (THR),
        .NUM_OUT    (NO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .I_FTk (I_FTk),
        .O_BTk (O_BTk),
        .O_FTk (O_FTk),
        .I_BTk (I_BTk),
        .O_Grt (O_Grt),
        .O_Err (O_Err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard model ----------------
    typedef struct {
        FTk_t          tok;
        logic [NO-1:0] mask;
        logic [NO-1:0] rem;
    } sb_entry_t;

    typedef enum {M_IDLE, M_BODY, M_DROP} m_state_t;

    sb_entry_t     mq[$];
    m_state_t      m_state = M_IDLE;
    logic [NO-1:0] m_mask  = '0;
    logic          m_err   = 1'b0;
    logic          m_btk   = 1'b0;
    int            dcnt[NO] = '{default: 0};

    // Sampled mid-cycle: predicts the state right after the coming edge.
    always @(negedge clock) begin
        int            occ0;
        bit            popped;
        bit            store;
        logic [NO-1:0] hm;
        logic [NO-1:0] smask;
        sb_entry_t     e;
        if (reset) begin
            mq.delete();
            m_state = M_IDLE;
            m_mask  = '0;
            m_err   = 1'b0;
            m_btk   = 1'b0;
        end else begin
            occ0   = mq.size();
            popped = 0;
            store  = 0;
            smask  = '0;
            m_btk  = (occ0 >= THR);
            if (occ0 > 0) begin
                e = mq[0];
                for (int i = 0; i < NO; i++) begin
                    if (e.rem[i] && !I_BTk[i].n) begin
                        e.rem[i] = 1'b0;
                        dcnt[i]++;
                    end
                end
                if (e.rem == '0) begin
                    mq.delete(0);
                    popped = 1;
                end else begin
                    mq[0] = e;
                end
            end
            if (I_FTk.v) begin
                hm = I_FTk.d[NO-1:0];
                if (m_state == M_DROP) begin
                    if (I_FTk.r) m_state = M_IDLE;
                end else if (I_FTk.a) begin
                    if (m_state == M_BODY) m_err = 1'b1;
                    if (hm != '0) begin
                        store   = 1;
                        smask   = hm;
                        m_mask  = hm;
                        m_state = I_FTk.r ? M_IDLE : M_BODY;
                    end else begin
                        m_state = I_FTk.r ? M_IDLE : M_DROP;
                    end
                end else if (m_state == M_BODY) begin
                    store = 1;
                    smask = m_mask;
                    if (I_FTk.r) m_state = M_IDLE;
                end else begin
                    m_err = 1'b1;
                end
                if (store) begin
                    if (occ0 == DEPTH && !popped) begin
                        m_err = 1'b1;
                    end else begin
                        e.tok  = I_FTk;
                        e.mask = smask;
                        e.rem  = smask;
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        FTk_t          exp;
        logic [NO-1:0] g;
        g = (mq.size() > 0) ? mq[0].mask : '0;
        for (int i = 0; i < NO; i++) begin
            exp = (mq.size() > 0 && mq[0].rem[i]) ? mq[0].tok : '0;
            chk($sformatf("%s ftk%0d", tag, i), 64'(O_FTk[i]), 64'(exp));
        end
        chk({tag, " grt"}, 64'(O_Grt), 64'(g));
        chk({tag, " btk"}, 64'(O_BTk.n), 64'(m_btk));
        chk({tag, " err"}, 64'(O_Err), 64'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_stall(input logic [NO-1:0] m);
        for (int i = 0; i < NO; i++) I_BTk[i].n = m[i];
    endtask

    task automatic drive(input logic v, input logic a, input logic r,
                         input logic [31:0] d, input string tag);
        I_FTk.v = v;
        I_FTk.a = a;
        I_FTk.r = r;
        I_FTk.d = d;
        step(tag);
    endtask

    task automatic idle(input int n, input string tag);
        I_FTk = '0;
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        I_FTk = '0;
        while (mq.size() > 0 && n < 100) begin
            step(tag);
            n++;
        end
        chk({tag, " drain bound"}, 64'(n < 100), 64'(1));
        chk({tag, " empty grt"}, 64'(O_Grt), 64'(0));
    endtask

    task automatic apply_reset(input string tag);
        I_FTk = '0;
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NO; i++)
            chk($sformatf("%s rst ftk%0d", tag, i), 64'(O_FTk[i]), 64'(0));
        chk({tag, " rst grt"}, 64'(O_Grt), 64'(0));
        chk({tag, " rst btk"}, 64'(O_BTk.n), 64'(0));
        chk({tag, " rst err"}, 64'(O_Err), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_deliv(input string tag, input int base[NO],
                             input int e0, input int e1, input int e2, input int e3);
        int ex[NO];
        ex = '{e0, e1, e2, e3};
        for (int i = 0; i < NO; i++)
            chk($sformatf("%s deliv ch%0d", tag, i), 64'(dcnt[i] - base[i]), 64'(ex[i]));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          v;
        logic          a;
        logic          r;
        logic [31:0]   d;
        logic [NO-1:0] stall;
        logic [NO-1:0] exp_v;
        logic [NO-1:0] exp_grt;
        logic          exp_err;
    } vec_t;

    vec_t vt[12];
    int   snap[NO];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NO-1:0] vm;

        // mask 0101, header + 3 bodies, then idle
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0005, 4'b0000, 4'b0101, 4'b0101, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_00A1, 4'b0000, 4'b0101, 4'b0101, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_00A2, 4'b0000, 4'b0101, 4'b0101, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 32'h0000_00A3, 4'b0000, 4'b0101, 4'b0101, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        // mask 1111 single-token message, channel 3 stalled 5 cycles
        vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_000F, 4'b1000, 4'b1111, 4'b1111, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1000, 4'b1000, 4'b1111, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1000, 4'b1000, 4'b1111, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1000, 4'b1000, 4'b1111, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1000, 4'b1000, 4'b1111, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1000, 4'b1000, 4'b1111, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        reset = 1'b1;
        I_FTk = '0;
        set_stall('0);
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < NO; i++)
            chk($sformatf("reset ftk%0d", i), 64'(O_FTk[i]), 64'(0));
        chk("reset grt", 64'(O_Grt), 64'(0));
        chk("reset btk", 64'(O_BTk.n), 64'(0));
        chk("reset err", 64'(O_Err), 64'(0));
        reset = 1'b0;
        idle(2, "post reset");

        // table-driven: mask 0101 stream and partial stall on 1111
        snap = dcnt;
        for (int k = 0; k < 12; k++) begin
            set_stall(vt[k].stall);
            drive(vt[k].v, vt[k].a, vt[k].r, vt[k].d, $sformatf("vec%0d", k));
            for (int i = 0; i < NO; i++) vm[i] = O_FTk[i].v;
            chk($sformatf("vec%0d valid", k), 64'(vm), 64'(vt[k].exp_v));
            chk($sformatf("vec%0d grt", k), 64'(O_Grt), 64'(vt[k].exp_grt));
            chk($sformatf("vec%0d err", k), 64'(O_Err), 64'(vt[k].exp_err));
            if (k == 4) begin
                chk_deliv("m0101", snap, 4, 0, 4, 0);
                snap = dcnt;
            end
        end
        chk_deliv("m1111", snap, 1, 1, 1, 1);

        // fill to full with every channel stalled, then one overflow
        set_stall(4'hF);
        snap = dcnt;
        for (int t = 0; t < 17; t++) begin
            drive(1'b1, (t == 0), 1'b0, (t == 0) ? 32'h0000_000F : 32'h100 + t,
                  $sformatf("ovf%0d", t));
            if (t == 11) chk("btk at occ 12", 64'(O_BTk.n), 64'(0));
            if (t == 12) chk("btk one cycle later", 64'(O_BTk.n), 64'(1));
            if (t == 15) chk("err at full", 64'(O_Err), 64'(0));
            if (t == 16) chk("err on overflow", 64'(O_Err), 64'(1));
        end
        set_stall('0);
        drain("ovf");
        chk_deliv("ovf", snap, 16, 16, 16, 16);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_01FF, "ovf close");
        drain("ovf close");
        chk("err sticky", 64'(O_Err), 64'(1));
        apply_reset("after ovf");
        idle(1, "after ovf");

        // zero-mask message dropped, then mask 0010 single token
        snap = dcnt;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, "m0 hdr");
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0B01, "m0 b1");
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0B02, "m0 b2");
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0002, "m2 hdr");
        drain("m0");
        chk_deliv("m0", snap, 0, 1, 0, 0);
        chk("m0 no err", 64'(O_Err), 64'(0));

        // protocol errors: stray body, header inside body
        snap = dcnt;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0BAD, "stray");
        chk("stray err", 64'(O_Err), 64'(1));
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0003, "p hdr1");
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0031, "p b1");
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0004, "p hdr2");
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0041, "p b2");
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0008, "p hdr3");
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0081, "p b3");
        drain("proto");
        chk_deliv("proto", snap, 2, 2, 2, 2);
        chk("proto err held", 64'(O_Err), 64'(1));

        // reset with 6 tokens stored
        set_stall(4'hF);
        snap = dcnt;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_000F, "mid hdr");
        for (int t = 0; t < 5; t++)
            drive(1'b1, 1'b0, 1'b0, 32'h200 + t, $sformatf("mid b%0d", t));
        I_FTk = '0;
        chk("mid grt before reset", 64'(O_Grt), 64'(4'hF));
        apply_reset("mid");
        set_stall('0);
        idle(10, "mid after");
        chk_deliv("mid", snap, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
